bmd_scan_scheduler: RTL and testbench

// - Shares one combinational bmd classifier (bmdrange[2:0] -> normal/abnormal) between N_CH patient channels.
// - Grants channels round-robin and registers each channel's 3-bit range code for classification.
// - Returns a one-cycle result strobe with the channel tag.
// - Tracks consecutive-abnormal streaks per channel and raises a sticky per-channel alarm.

---
 rtl/bmd_pkg.sv | 18 +
 rtl/bmd.sv | 41 ++++
 rtl/rr_arbiter.sv | 39 +++
 rtl/bmd_scan_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_bmd_scan_scheduler.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bmd_pkg.sv
// Shared definitions for the bmd scan scheduler slice.
// Contents: scheduler state enum, range-code width, default sizing constants.
package bmd_pkg;

  localparam int RANGE_W       = 3;
  localparam int DEF_N_CH      = 4;
  localparam int DEF_CH_W      = 2;
  localparam int DEF_ALARM_CNT = 3;
  localparam int DEF_CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    EVAL   = 2'd2,
    REPORT = 2'd3
  } state_t;

endpackage

// File: rtl/bmd.sv
// Combinational bmd classifier: maps a 3-bit bone-density range code to
// normal/abnormal flags.
// Ports:
//   bmdrange  in   RANGE_W  range code
//   normal    out  1        code is in a normal band
//   abnormal  out  1        code is in an abnormal band
// Codes 0 and 7 are invalid (both flags 0). Code 6 is a borderline band that
// raises both flags; downstream treats it as abnormal.
module bmd
  import bmd_pkg::*;
(
  input  logic [RANGE_W-1:0] bmdrange,
  output logic               normal,
  output logic               abnormal
);

  // band decode
  always_comb begin
    normal   = 1'b0;
    abnormal = 1'b0;
    case (bmdrange)
      3'd1, 3'd2: begin
        normal   = 1'b1;
        abnormal = 1'b0;
      end
      3'd3, 3'd4, 3'd5: begin
        normal   = 1'b0;
        abnormal = 1'b1;
      end
      3'd6: begin
        normal   = 1'b1;
        abnormal = 1'b1;
      end
      default: begin
        normal   = 1'b0;
        abnormal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, else the
// first set request below ptr (wrap-around). The caller owns the pointer.
// Ports:
//   req    in   N_CH  request vector
//   ptr    in   CH_W  highest-priority channel index
//   grant  out  CH_W  chosen channel (valid when found=1)
//   found  out  1     at least one request is set
module rr_arbiter #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] grant,
  output logic            found
);

  logic [CH_W-1:0] grant_hi_s;
  logic [CH_W-1:0] grant_lo_s;
  logic            found_hi_s;
  logic            found_lo_s;

  // scan downward so the lowest index in each half is the one that sticks
  always_comb begin
    grant_hi_s = {CH_W{1'b0}};
    grant_lo_s = {CH_W{1'b0}};
    found_hi_s = 1'b0;
    found_lo_s = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      grant_hi_s = (req[k] && (CH_W'(k) >= ptr)) ? CH_W'(k) : grant_hi_s;
      found_hi_s = found_hi_s | (req[k] && (CH_W'(k) >= ptr));
      grant_lo_s = (req[k] && (CH_W'(k) <  ptr)) ? CH_W'(k) : grant_lo_s;
      found_lo_s = found_lo_s | (req[k] && (CH_W'(k) <  ptr));
    end
    found = found_hi_s | found_lo_s;
    grant = found_hi_s ? grant_hi_s : grant_lo_s;
  end

endmodule

// File: rtl/bmd_scan_scheduler.sv
// Shares one bmd classifier between N_CH channels. Channels are granted
// round-robin; each scan takes 4 cycles (IDLE->GRANT->EVAL->REPORT) and ends
// with a one-cycle result strobe. Per-channel abnormal streaks drive a sticky
// alarm.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req           per-channel scan request (held until ack)
//   range_flat    channel k code at [3k+2:3k]
//   ack           one-hot accept pulse
//   busy          scheduler not in IDLE
//   res_valid     result strobe; res_ch/res_normal/res_abnormal qualify with it
//   clear_alarm   per-channel alarm clear (level)
//   alarm         sticky per-channel alarm
module bmd_scan_scheduler
  import bmd_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int CH_W      = DEF_CH_W,
  parameter int ALARM_CNT = DEF_ALARM_CNT,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         req,
  input  logic [RANGE_W*N_CH-1:0] range_flat,
  output logic [N_CH-1:0]         ack,
  output logic                    busy,
  output logic                    res_valid,
  output logic [CH_W-1:0]         res_ch,
  output logic                    res_normal,
  output logic                    res_abnormal,
  input  logic [N_CH-1:0]         clear_alarm,
  output logic [N_CH-1:0]         alarm
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t               state_r;
  logic [CH_W-1:0]      rr_ptr_r;
  logic [CH_W-1:0]      ch_r;
  logic [RANGE_W-1:0]   code_r;
  logic                 norm_r;
  logic                 abn_r;

  logic [CH_W-1:0]      grant_s;
  logic                 found_s;
  logic [RANGE_W-1:0]   sel_code_s;
  logic [N_CH-1:0]      onehot_s;
  logic [CH_W-1:0]      ptr_next_s;
  logic                 norm_s;
  logic                 abn_s;
  logic                 eval_s;

  rr_arbiter #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr_r),
    .grant (grant_s),
    .found (found_s)
  );

  // classifier only ever sees the captured code, never the live inputs
  bmd u_bmd (
    .bmdrange (code_r),
    .normal   (norm_s),
    .abnormal (abn_s)
  );

  // winner's code, one-hot ack and the pointer slot after the winner
  always_comb begin
    sel_code_s = {RANGE_W{1'b0}};
    onehot_s   = {N_CH{1'b0}};
    for (int k = 0; k < N_CH; k++) begin
      sel_code_s  = (grant_s == CH_W'(k)) ? range_flat[k*RANGE_W +: RANGE_W] : sel_code_s;
      onehot_s[k] = found_s && (grant_s == CH_W'(k));
    end
    ptr_next_s = (grant_s == CH_W'(N_CH - 1)) ? {CH_W{1'b0}} : grant_s + 1'b1;
  end

  assign eval_s = (state_r == EVAL);

  // scan FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      rr_ptr_r     <= {CH_W{1'b0}};
      ch_r         <= {CH_W{1'b0}};
      code_r       <= {RANGE_W{1'b0}};
      norm_r       <= 1'b0;
      abn_r        <= 1'b0;
      ack          <= {N_CH{1'b0}};
      busy         <= 1'b0;
      res_valid    <= 1'b0;
      res_ch       <= {CH_W{1'b0}};
      res_normal   <= 1'b0;
      res_abnormal <= 1'b0;
    end else begin
      ack       <= {N_CH{1'b0}};
      res_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            ack      <= onehot_s;
            code_r   <= sel_code_s;
            ch_r     <= grant_s;
            rr_ptr_r <= ptr_next_s;
            busy     <= 1'b1;
            state_r  <= GRANT;
          end else begin
            busy     <= 1'b0;
            state_r  <= IDLE;
          end
        end
        GRANT: begin
          norm_r  <= norm_s;
          abn_r   <= abn_s;
          busy    <= 1'b1;
          state_r <= EVAL;
        end
        EVAL: begin
          busy    <= 1'b1;
          state_r <= REPORT;
        end
        REPORT: begin
          res_valid    <= 1'b1;
          res_ch       <= ch_r;
          res_normal   <= norm_r;
          res_abnormal <= abn_r;
          busy         <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [CNT_W-1:0] streak_r;
    logic [CNT_W-1:0] streak_nxt_s;
    logic             hit_s;
    logic             set_s;
    logic             alarm_r;

    // streak update for this channel; a borderline code (both flags) counts as abnormal
    always_comb begin
      hit_s = eval_s && (ch_r == CH_W'(k));
      if (hit_s && abn_r) begin
        streak_nxt_s = (streak_r == CNT_MAX) ? streak_r : streak_r + 1'b1;
      end else if (hit_s && norm_r) begin
        streak_nxt_s = {CNT_W{1'b0}};
      end else begin
        streak_nxt_s = streak_r;
      end
      set_s = hit_s && abn_r && (streak_nxt_s >= CNT_W'(ALARM_CNT));
    end

    // streak register and sticky alarm; a set on the same edge beats a clear
    always_ff @(posedge clk) begin
      if (rst) begin
        streak_r <= {CNT_W{1'b0}};
        alarm_r  <= 1'b0;
      end else begin
        streak_r <= streak_nxt_s;
        if (set_s) begin
          alarm_r <= 1'b1;
        end else if (clear_alarm[k]) begin
          alarm_r <= 1'b0;
        end else begin
          alarm_r <= alarm_r;
        end
      end
    end

    assign alarm[k] = alarm_r;
  end

endmodule

// File: tb/tb_bmd_scan_scheduler.sv
module tb_bmd_scan_scheduler;

  localparam int N  = 4;
  localparam int AC = 3;
  localparam int SMAX = 15;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] range_flat;
  logic [3:0]  ack;
  logic        busy;
  logic        res_valid;
  logic [1:0]  res_ch;
  logic        res_normal;
  logic        res_abnormal;
  logic [3:0]  clear_alarm;
  logic [3:0]  alarm;

  logic [2:0]  gold_code;
  logic        gold_n;
  logic        gold_a;

  bmd_scan_scheduler #(.N_CH(4), .CH_W(2), .ALARM_CNT(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .range_flat(range_flat),
    .ack(ack), .busy(busy), .res_valid(res_valid), .res_ch(res_ch),
    .res_normal(res_normal), .res_abnormal(res_abnormal),
    .clear_alarm(clear_alarm), .alarm(alarm)
  );

  bmd u_gold (.bmdrange(gold_code), .normal(gold_n), .abnormal(gold_a));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int ch; int norm; int abn; int due; } exp_t;
  exp_t sb[$];

  bit   tbl_n[8];
  bit   tbl_a[8];
  logic [2:0] cn, ca;

  int   cyc = 0;
  int   ptr = 0;
  int   age = -1;          // edges since the current scan was granted, -1 = free
  int   cur_ch;
  bit   cur_n, cur_a;
  int   streak[N];
  logic [3:0] m_ack   = 4'h0;
  logic [3:0] m_alarm = 4'h0;

  always @(posedge clk) begin
    logic [3:0] setm;
    bit found;
    int c;
    cyc++;
    setm = 4'h0;
    if (rst) begin
      ptr = 0; age = -1; m_ack = 4'h0; m_alarm = 4'h0;
      for (int k = 0; k < N; k++) streak[k] = 0;
      sb.delete();
    end else begin
      m_ack = 4'h0;
      if (age < 0) begin
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          c = (ptr + i) % N;
          if (!found && req[c]) begin found = 1'b1; cur_ch = c; end
        end
        if (found) begin
          cur_n = tbl_n[range_flat[3*cur_ch +: 3]];
          cur_a = tbl_a[range_flat[3*cur_ch +: 3]];
          sb.push_back('{cur_ch, int'(cur_n), int'(cur_a), cyc + 3});
          ptr = (cur_ch + 1) % N;
          age = 0;
          m_ack[cur_ch] = 1'b1;
        end
      end else begin
        age++;
        if (age == 2) begin
          if (cur_a) begin
            if (streak[cur_ch] < SMAX) streak[cur_ch]++;
            if (streak[cur_ch] >= AC) setm[cur_ch] = 1'b1;
          end else if (cur_n) begin
            streak[cur_ch] = 0;
          end
        end
        if (age == 3) age = -1;
      end
      m_alarm = (m_alarm & ~clear_alarm) | setm;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("ack", 32'(ack), 32'(m_ack));
      chk("busy", 32'(busy), 32'(age >= 0));
      chk("alarm", 32'(alarm), 32'(m_alarm));
      if (res_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("res_unexpected", 32'(res_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("res_ch", 32'(res_ch), 32'(e.ch));
          chk("res_normal", 32'(res_normal), 32'(e.norm));
          chk("res_abnormal", 32'(res_abnormal), 32'(e.abn));
          chk("res_latency", 32'(cyc), 32'(e.due));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("res_missing", 32'(res_valid), 32'd1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic scan(input int ch, input logic [2:0] code);
    int t;
    @(negedge clk);
    range_flat[3*ch +: 3] = code;
    req[ch] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (ack[ch] !== 1'b1 && t < 60);
    if (ack[ch] !== 1'b1) chk("scan_timeout", 32'(ack), 32'(1 << ch));
    req[ch] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = 4'h0; clear_alarm = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(output int t);
    t = 0;
    do begin @(negedge clk); t++; end while (ack == 4'h0 && t < 60);
  endtask

  initial begin
    int t, rv, prev;
    logic [2:0] code;
    logic [3:0] a0;
    rst = 1'b1; req = 4'h0; range_flat = 12'h0; clear_alarm = 4'h0;
    gold_code = 3'd0;
    cn = 3'd0; ca = 3'd0;
    for (int c = 7; c >= 0; c--) begin
      gold_code = 3'(c);
      #1;
      tbl_n[c] = gold_n;
      tbl_a[c] = gold_a;
      if (gold_n && !gold_a) cn = 3'(c);
      if (gold_a && !gold_n) ca = 3'(c);
    end

    // reset held with all requests raised
    @(negedge clk);
    req = 4'hF;
    mon_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_alarm", 32'(alarm), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    rst = 1'b0; req = 4'h0;

    // single scan on ch2
    scan(2, cn);
    t = 0;
    do begin @(negedge clk); t++; end while (res_valid !== 1'b1 && t < 10);
    chk("single_latency", 32'(t), 32'd3);
    chk("single_ch", 32'(res_ch), 32'd2);
    chk("single_norm", 32'(res_normal), 32'd1);
    chk("single_abn", 32'(res_abnormal), 32'd0);

    // round-robin with all channels held
    do_reset();
    range_flat = {4{cn}};
    req = 4'hF;
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_ack(t);
      chk("rr_order", 32'(ack), 32'(1 << (n % 4)));
      if (n > 0) chk("rr_gap", 32'(cyc - prev), 32'd4);
      prev = cyc;
    end
    req = 4'h0;
    repeat (6) @(negedge clk);

    // alarm on ch1
    do_reset();
    repeat (3) scan(1, ca);
    repeat (2) @(negedge clk);
    chk("alarm_set", 32'(alarm[1]), 32'd1);
    scan(1, cn);
    repeat (4) @(negedge clk);
    chk("alarm_sticky", 32'(alarm[1]), 32'd1);
    clear_alarm[1] = 1'b1;
    @(negedge clk);
    clear_alarm[1] = 1'b0;
    chk("alarm_clear", 32'(alarm[1]), 32'd0);

    // set beats clear on the same edge
    repeat (3) scan(3, ca);
    @(negedge clk);
    clear_alarm[3] = 1'b1;
    @(negedge clk);
    clear_alarm[3] = 1'b0;
    chk("set_wins", 32'(alarm[3]), 32'd1);
    repeat (4) @(negedge clk);

    // reset in EVAL drops the result and zeroes streaks
    do_reset();
    repeat (2) scan(2, ca);
    repeat (4) @(negedge clk);
    scan(2, ca);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rv = 0;
    repeat (4) begin @(negedge clk); rv += int'(res_valid); end
    chk("midrst_novalid", 32'(rv), 32'd0);
    req = 4'hF;
    wait_ack(t);
    a0 = ack;
    req = 4'h0;
    chk("midrst_first", 32'(a0), 32'd1);
    repeat (4) @(negedge clk);
    scan(2, ca);
    repeat (2) @(negedge clk);
    chk("midrst_streak0", 32'(alarm[2]), 32'd0);
    repeat (4) @(negedge clk);

    // randomized traffic
    for (int cy = 0; cy < 3000; cy++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (req[k] && ack[k]) begin
          req[k] = 1'b0;
        end else if (req[k] && $urandom_range(0, 63) == 0) begin
          req[k] = 1'b0;
        end else if (!req[k] && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 3))
            0: code = cn;
            1: code = ca;
            default: code = 3'($urandom);
          endcase
          range_flat[3*k +: 3] = code;
          req[k] = 1'b1;
        end
      end
      clear_alarm = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
      rst = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    rst = 1'b0; req = 4'h0; clear_alarm = 4'h0;
    repeat (10) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
